// File: rtl/btn_cond.sv
// btn_cond -- front-panel input conditioner for the washer controller.
//
// Takes the four raw asynchronous push-button levels and hands the control
// FSM clean versions: synchronised + debounced held levels, single-cycle
// press pulses, and a child-lock that toggles when mode and water are held
// together for long enough.
//
// Ports
//   clk                          system clock, all logic on the rising edge
//   rst                          synchronous active-high reset
//   a_mod, a_run, a_wat, a_pwr   raw button levels (asynchronous, active-high)
//   lck_clr                      synchronous clear of the child-lock
//   h_mod, h_run, h_wat, h_pwr   debounced held levels
//   p_mod, p_run, p_wat, p_pwr   one-cycle press pulses (0->1 of the held level)
//   locked                       child-lock state
//   lck_tgl                      one-cycle pulse on every lock toggle
//
// Parameters
//   DEB_WAIT   consecutive cycles a synchronised level must differ from the
//              held level before it is accepted (>= 1)
//   LCK_WAIT   consecutive cycles mode and water must both be held before
//              the lock toggles (>= 1)
//
// Lock FSM states
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for h_mod and h_wat to be high together
//   ST_ARMED | both held, counting towards the toggle
//   ST_FIRED | toggle done, waiting for both buttons to be released

module btn_cond #(
    parameter int DEB_WAIT = 500000,
    parameter int LCK_WAIT = 200000000
) (
    input  logic clk,
    input  logic rst,
    input  logic a_mod,
    input  logic a_run,
    input  logic a_wat,
    input  logic a_pwr,
    input  logic lck_clr,
    output logic h_mod,
    output logic h_run,
    output logic h_wat,
    output logic h_pwr,
    output logic p_mod,
    output logic p_run,
    output logic p_wat,
    output logic p_pwr,
    output logic locked,
    output logic lck_tgl
);

    // Bit order of every per-button vector: [0] mod, [1] run, [2] wat, [3] pwr.
    localparam int B_MOD = 0;
    localparam int B_WAT = 2;

    localparam int DW = (DEB_WAIT > 1) ? $clog2(DEB_WAIT) : 1;
    localparam int LW = (LCK_WAIT > 1) ? $clog2(LCK_WAIT) : 1;

    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_WAIT - 1);
    // The ARMED counter starts at 0 on the edge that enters ARMED, so the
    // toggle is taken on the edge that would bring it to LCK_WAIT-1; that
    // makes the toggle land LCK_WAIT edges after both levels first go high.
    localparam logic [LW-1:0] LCK_PEN  = LW'((LCK_WAIT >= 2) ? (LCK_WAIT - 2) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRED = 2'd2
    } lck_state_t;

    logic [3:0]         raw;
    logic [3:0]         s1;
    logic [3:0]         s2;
    logic [3:0]         h;
    logic [3:0]         h_nxt;
    logic [3:0]         rise;
    logic [3:0]         p;
    logic [3:0]         p_nxt;
    logic [3:0][DW-1:0] cnt;
    logic [3:0][DW-1:0] cnt_nxt;

    lck_state_t         state;
    lck_state_t         state_nxt;
    logic [LW-1:0]      lcnt;
    logic [LW-1:0]      lcnt_nxt;
    logic               fire;
    logic               both_held;
    logic               both_free;
    logic               locked_nxt;
    logic               tgl_nxt;
    logic               combo_sup;
    logic [3:0]         sup_mask;

    assign raw = {a_pwr, a_wat, a_run, a_mod};

    assign h_mod = h[0];
    assign h_run = h[1];
    assign h_wat = h[2];
    assign h_pwr = h[3];
    assign p_mod = p[0];
    assign p_run = p[1];
    assign p_wat = p[2];
    assign p_pwr = p[3];

    // Debounce: a differing synchronised level must persist DEB_WAIT cycles;
    // any return to the held value drops the count back to zero.
    always_comb begin
        h_nxt   = h;
        rise    = '0;
        cnt_nxt = '0;
        for (int i = 0; i < 4; i++) begin
            if (s2[i] != h[i]) begin
                if (cnt[i] == DEB_LAST) begin
                    h_nxt[i] = s2[i];
                    rise[i]  = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    assign both_held = h[B_MOD] & h[B_WAT];
    assign both_free = ~h[B_MOD] & ~h[B_WAT];

    always_comb begin
        state_nxt = state;
        lcnt_nxt  = lcnt;
        fire      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (both_held) begin
                    lcnt_nxt = '0;
                    if (LCK_WAIT == 1) begin
                        fire      = 1'b1;
                        state_nxt = ST_FIRED;
                    end else begin
                        state_nxt = ST_ARMED;
                    end
                end
            end
            ST_ARMED: begin
                if (!both_held) begin
                    state_nxt = ST_IDLE;
                end else if (lcnt == LCK_PEN) begin
                    fire      = 1'b1;
                    state_nxt = ST_FIRED;
                end else begin
                    lcnt_nxt = lcnt + 1'b1;
                end
            end
            ST_FIRED: begin
                if (both_free) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Clear beats a simultaneous toggle; the FSM still moves to FIRED.
    assign locked_nxt = lck_clr ? 1'b0 : (fire ? ~locked : locked);
    assign tgl_nxt    = fire & ~lck_clr;

    // Pulses are registered, so suppression is evaluated on the values the
    // design will hold in the cycle the pulse is visible: FSM in ARMED or
    // FIRED, or about to leave IDLE because both held levels are high.
    assign combo_sup = (state_nxt != ST_IDLE) || (h_nxt[B_MOD] && h_nxt[B_WAT]);
    assign sup_mask  = {1'b0, combo_sup, 1'b0, combo_sup}
                     | {1'b0, locked_nxt, locked_nxt, locked_nxt};
    assign p_nxt     = rise & ~sup_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            h       <= '0;
            p       <= '0;
            cnt     <= '0;
            state   <= ST_IDLE;
            lcnt    <= '0;
            locked  <= 1'b0;
            lck_tgl <= 1'b0;
        end else begin
            s1      <= raw;
            s2      <= s1;
            h       <= h_nxt;
            p       <= p_nxt;
            cnt     <= cnt_nxt;
            state   <= state_nxt;
            lcnt    <= lcnt_nxt;
            locked  <= locked_nxt;
            lck_tgl <= tgl_nxt;
        end
    end

endmodule

// File: tb/tb_btn_cond.sv
module tb_btn_cond;

    localparam int DEB = 5;
    localparam int LCK = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       lck_clr;
    logic [3:0] a;
    logic       h_mod, h_run, h_wat, h_pwr;
    logic       p_mod, p_run, p_wat, p_pwr;
    logic       locked, lck_tgl;

    always #5 clk = ~clk;

    btn_cond #(.DEB_WAIT(DEB), .LCK_WAIT(LCK)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_mod   (a[0]),
        .a_run   (a[1]),
        .a_wat   (a[2]),
        .a_pwr   (a[3]),
        .lck_clr (lck_clr),
        .h_mod   (h_mod),
        .h_run   (h_run),
        .h_wat   (h_wat),
        .h_pwr   (h_pwr),
        .p_mod   (p_mod),
        .p_run   (p_run),
        .p_wat   (p_wat),
        .p_pwr   (p_pwr),
        .locked  (locked),
        .lck_tgl (lck_tgl)
    );

    logic [3:0] h_obs;
    logic [3:0] p_obs;
    assign h_obs = {h_pwr, h_wat, h_run, h_mod};
    assign p_obs = {p_pwr, p_wat, p_run, p_mod};

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: two-stage sample delay, then "level accepted after DEB
    // consecutive differing cycles"; lock toggles when both held levels have
    // been high for LCK consecutive cycles, once per hold.
    logic [3:0] m_s1, m_s2, m_h, m_p;
    int         m_run [4];
    int         m_lrun;
    bit         m_fired;
    logic       m_locked, m_tgl;

    int         p_cnt [4];
    int         h_rise [4];
    int         tgl_cnt;
    logic [3:0] h_prev;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_h = '0; m_p = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_lrun = 0; m_fired = 0; m_locked = 1'b0; m_tgl = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] old_h;
        logic [3:0] rose;
        bit         fire;
        bit         combo;
        if (rst) begin
            model_reset();
            return;
        end
        old_h = m_h;
        rose  = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] == m_h[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_h[i]   = m_s2[i];
                    rose[i]  = m_s2[i];
                    m_run[i] = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = a;
        fire = 0;
        if (m_fired) begin
            if (!old_h[0] && !old_h[2]) m_fired = 0;
        end else if (old_h[0] && old_h[2]) begin
            m_lrun++;
            if (m_lrun == LCK) begin
                fire    = 1;
                m_fired = 1;
                m_lrun  = 0;
            end
        end else begin
            m_lrun = 0;
        end
        m_tgl = fire && !lck_clr;
        if (lck_clr)   m_locked = 1'b0;
        else if (fire) m_locked = ~m_locked;
        combo = m_fired || (m_lrun > 0) || (m_h[0] && m_h[2]);
        m_p = rose;
        if (combo) begin
            m_p[0] = 1'b0;
            m_p[2] = 1'b0;
        end
        if (m_locked) m_p[2:0] = 3'b000;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_eq("held",  {28'd0, h_obs}, {28'd0, m_h});
        check_eq("pulse", {28'd0, p_obs}, {28'd0, m_p});
        check_eq("lock",  {30'd0, locked, lck_tgl}, {30'd0, m_locked, m_tgl});
        for (int i = 0; i < 4; i++) begin
            if (p_obs[i] === 1'b1) p_cnt[i]++;
            if (h_obs[i] === 1'b1 && h_prev[i] === 1'b0) h_rise[i]++;
        end
        if (lck_tgl === 1'b1) tgl_cnt++;
        h_prev = h_obs;
    endtask

    task automatic wait_pulse(input int idx, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (p_obs[idx] !== 1'b1 && n < limit);
    endtask

    task automatic combo(input int hold);
        a[0] = 1'b1;
        repeat (4) step();
        a[2] = 1'b1;
        repeat (hold) step();
        a[0] = 1'b0;
        a[2] = 1'b0;
        repeat (12) step();
    endtask

    int n;
    int p0 [4];
    int t0;
    int r0;
    int clr_hits;
    int dur [4];

    initial begin
        for (int i = 0; i < 4; i++) begin
            p_cnt[i] = 0; h_rise[i] = 0;
        end
        tgl_cnt = 0;
        h_prev  = '0;
        model_reset();
        a = '0; lck_clr = 1'b0; rst = 1'b1;
        repeat (3) step();
        check_eq("rst_outs", {22'd0, h_obs, p_obs, locked, lck_tgl}, 32'd0);
        rst = 1'b0;
        repeat (3) step();

        // clean press of run
        p0[1] = p_cnt[1];
        a[1] = 1'b1;
        wait_pulse(1, 20, n);
        check_eq("run_latency", n, 7);
        repeat (30 - n) step();
        a[1] = 1'b0;
        repeat (6) step();
        check_eq("run_held_rel6", {31'd0, h_run}, 32'd1);
        step();
        check_eq("run_held_rel7", {31'd0, h_run}, 32'd0);
        repeat (8) step();
        check_eq("run_pulses", p_cnt[1] - p0[1], 1);

        // bouncing mode
        p0[0] = p_cnt[0]; r0 = h_rise[0];
        for (int k = 0; k < 10; k++) begin
            a[0] = ~a[0];
            step();
            step();
        end
        a[0] = 1'b1;
        wait_pulse(0, 20, n);
        check_eq("mod_latency", n, 7);
        repeat (10) step();
        a[0] = 1'b0;
        repeat (12) step();
        check_eq("mod_pulses", p_cnt[0] - p0[0], 1);
        check_eq("mod_h_rises", h_rise[0] - r0, 1);

        // lock with a combo, then locked suppression
        p0[0] = p_cnt[0]; p0[2] = p_cnt[2]; t0 = tgl_cnt;
        combo(40);
        check_eq("lock_mod_pulses", p_cnt[0] - p0[0], 1);
        check_eq("lock_wat_pulses", p_cnt[2] - p0[2], 0);
        check_eq("lock_tgls", tgl_cnt - t0, 1);
        check_eq("lock_state", {31'd0, locked}, 32'd1);
        p0[1] = p_cnt[1]; p0[3] = p_cnt[3];
        a[1] = 1'b1; repeat (12) step(); a[1] = 1'b0; repeat (10) step();
        a[3] = 1'b1; repeat (12) step(); a[3] = 1'b0; repeat (10) step();
        check_eq("locked_run_pulses", p_cnt[1] - p0[1], 0);
        check_eq("locked_pwr_pulses", p_cnt[3] - p0[3], 1);

        // short overlap: no toggle
        t0 = tgl_cnt; p0[2] = p_cnt[2];
        a[0] = 1'b1; repeat (4) step();
        a[2] = 1'b1; repeat (15) step();
        a[0] = 1'b0; a[2] = 1'b0; repeat (14) step();
        check_eq("short_tgls", tgl_cnt - t0, 0);
        check_eq("short_locked", {31'd0, locked}, 32'd1);
        check_eq("short_wat_pulses", p_cnt[2] - p0[2], 0);

        // unlock by combo
        t0 = tgl_cnt;
        combo(40);
        check_eq("unlock_tgls", tgl_cnt - t0, 1);
        check_eq("unlock_state", {31'd0, locked}, 32'd0);

        // relock, then clear
        combo(40);
        check_eq("relock_state", {31'd0, locked}, 32'd1);
        t0 = tgl_cnt;
        lck_clr = 1'b1; step(); lck_clr = 1'b0; step();
        check_eq("clr_state", {31'd0, locked}, 32'd0);
        check_eq("clr_tgls", tgl_cnt - t0, 0);

        // clear coinciding with the toggle edge
        t0 = tgl_cnt; clr_hits = 0;
        a[0] = 1'b1; a[2] = 1'b1;
        for (int k = 0; k < 50; k++) begin
            lck_clr = (!m_fired && m_h[0] && m_h[2] && m_lrun == LCK - 1);
            if (lck_clr) clr_hits++;
            step();
        end
        lck_clr = 1'b0;
        a[0] = 1'b0; a[2] = 1'b0;
        repeat (12) step();
        check_eq("clr_on_tgl_hits", clr_hits, 1);
        check_eq("clr_on_tgl_tgls", tgl_cnt - t0, 0);
        check_eq("clr_on_tgl_state", {31'd0, locked}, 32'd0);

        // reset mid-debounce
        a[1] = 1'b1; repeat (3) step();
        rst = 1'b1; step();
        check_eq("rst_deb_outs", {22'd0, h_obs, p_obs, locked, lck_tgl}, 32'd0);
        rst = 1'b0;
        repeat (12) step();
        a[1] = 1'b0; repeat (10) step();

        // reset mid-ARMED with power held through it
        a[3] = 1'b1; repeat (10) step();
        a[0] = 1'b1; a[2] = 1'b1; repeat (18) step();
        rst = 1'b1; step();
        check_eq("rst_arm_outs", {22'd0, h_obs, p_obs, locked, lck_tgl}, 32'd0);
        rst = 1'b0;
        wait_pulse(3, 20, n);
        check_eq("pwr_after_rst", n, 7);
        a = '0;
        repeat (40) step();

        // randomized phase
        for (int i = 0; i < 4; i++) dur[i] = $urandom_range(1, 40);
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < 4; i++) begin
                dur[i]--;
                if (dur[i] <= 0) begin
                    a[i] = ~a[i];
                    dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                        : $urandom_range(6, 60);
                end
            end
            lck_clr = ($urandom_range(0, 99) == 0);
            rst     = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 1'b0; lck_clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
